// File: rtl/video_pkg.sv
// Shared video definitions for the binary morphology stages.
//   RGB_W       : width of an RGB444 pixel word (12).
//   DEF_WIDTH   : default active pixels per line (400).
//   DEF_HEIGHT  : default active lines per frame (300).
//   dilate_state_t : control states of dilate_stream.
package video_pkg;

  localparam int RGB_W      = 12;
  localparam int DEF_WIDTH  = 400;
  localparam int DEF_HEIGHT = 300;

  typedef enum logic [2:0] {
    IDLE,
    PRIME,
    RUN,
    EOL_EXTRA,
    FLUSH
  } dilate_state_t;

endpackage

// File: rtl/line_buf_1b.sv
// One line of 1-bit pixel storage, WIDTH entries deep, single port.
// The read is asynchronous, so a same-cycle write returns the old contents
// on rdata (read-before-write); this lets two instances form a row cascade.
// Ports:
//   clk   : pixel clock
//   addr  : column address
//   we    : write enable
//   wdata : bit to store at addr on the clock edge
//   rdata : current contents of addr
module line_buf_1b
  import video_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int AW    = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic          we,
  input  logic          wdata,
  output logic          rdata
);

  logic mem [WIDTH];

  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

endmodule

// File: rtl/dilate_stream.sv
// Binary 3x3 dilation of a raster-order valid/ready pixel stream, zero padded
// at every frame border. Output pixel (x,y) leaves one cycle after input
// (x+1,y+1) is accepted; the right column and bottom row are produced from
// the EOL_EXTRA and FLUSH stall states.
// Build option: define DILATE_CROSS_EN for a plus-shaped kernel (centre and
// four orthogonal neighbours); otherwise the full 3x3 square is used.
// Ports:
//   clk, rst (async, active-low)
//   in_valid/in_ready  : input handshake; in_sof, in_eol, in_bit qualified by in_valid
//   out_valid/out_ready: output handshake; out_sof at (0,0), out_eol at x=WIDTH-1
//   out_value          : dilated bit replicated to 12 bits
module dilate_stream
  import video_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT,
  parameter int CW     = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sof,
  input  logic             in_eol,
  input  logic             in_bit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sof,
  output logic             out_eol,
  output logic [RGB_W-1:0] out_value
);

  localparam int AW = $clog2(WIDTH);
  localparam logic [CW-1:0] X_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] X_END  = CW'(WIDTH);
  localparam logic [CW-1:0] Y_LAST = CW'(HEIGHT - 1);
  localparam logic [CW-1:0] ONE    = CW'(1);
  localparam logic [CW-1:0] TWO    = CW'(2);

  // Window columns are {row above, centre row, row below} relative to the
  // output pixel: col_l/col_c are registered, col_r is the column arriving now.
  function automatic logic kernel(input logic [2:0] l, input logic [2:0] c,
                                  input logic [2:0] r);
`ifdef DILATE_CROSS_EN
    return (|c) | l[1] | r[1];
`else
    return |{l, c, r};
`endif
  endfunction

  dilate_state_t state, state_nxt;
  logic [CW-1:0] x, y, x_nxt, y_nxt;
  logic          active;
  logic [2:0]    col_l, col_c, col_r;
  logic [AW-1:0] lb_addr;
  logic          lb_we, row1_rd, row2_rd;
  logic          free, in_fire, shift, emit, emit_sof, emit_eol, emit_bit;
  logic          unused_eol;

  // Line position is taken from the x counter alone; in_eol is advisory.
  assign unused_eol = in_eol;

  assign free     = !out_valid || out_ready;
  assign emit_bit = kernel(col_l, col_c, col_r);

  always_comb begin
    state_nxt = state;
    x_nxt     = x;
    y_nxt     = y;
    shift     = 1'b0;
    emit      = 1'b0;
    emit_sof  = 1'b0;
    emit_eol  = 1'b0;
    lb_we     = 1'b0;
    col_r     = 3'b000;
    lb_addr   = (x < X_END) ? x[AW-1:0] : '0;
    in_ready  = active && free &&
                (state == IDLE || state == PRIME || state == RUN);
    in_fire   = in_valid && in_ready;
    case (state)
      IDLE: begin
        if (in_fire && in_sof) begin
          lb_we     = 1'b1;
          x_nxt     = ONE;
          y_nxt     = '0;
          state_nxt = PRIME;
        end
      end
      PRIME: begin
        if (in_fire) begin
          lb_we = 1'b1;
          if (in_sof) begin
            x_nxt = ONE;
            y_nxt = '0;
          end else if (x == X_LAST) begin
            x_nxt     = '0;
            y_nxt     = ONE;
            state_nxt = RUN;
          end else begin
            x_nxt = x + ONE;
          end
        end
      end
      RUN: begin
        // Row y-2 does not exist while the second line is arriving.
        col_r = {(y >= TWO) ? row2_rd : 1'b0, row1_rd, in_bit};
        if (in_fire) begin
          lb_we = 1'b1;
          if (in_sof) begin
            x_nxt     = ONE;
            y_nxt     = '0;
            state_nxt = PRIME;
          end else begin
            shift    = 1'b1;
            emit     = (x != '0);
            emit_sof = (x == ONE) && (y == ONE);
            if (x == X_LAST) begin
              x_nxt     = '0;
              state_nxt = EOL_EXTRA;
            end else begin
              x_nxt = x + ONE;
            end
          end
        end
      end
      EOL_EXTRA: begin
        // Right-edge pixel: col_r stays zero for the padding column.
        if (free) begin
          emit     = 1'b1;
          emit_eol = 1'b1;
          if (y == Y_LAST) begin
            x_nxt     = '0;
            state_nxt = FLUSH;
          end else begin
            y_nxt     = y + ONE;
            state_nxt = RUN;
          end
        end
      end
      FLUSH: begin
        // Bottom row: the two stored rows plus a zero row below; x runs one
        // past the last column so the final pixel sees a zero right column.
        col_r = (x < X_END) ? {row2_rd, row1_rd, 1'b0} : 3'b000;
        if (free) begin
          shift    = 1'b1;
          emit     = (x != '0);
          emit_eol = (x == X_END);
          if (x == X_END) begin
            x_nxt     = '0;
            y_nxt     = '0;
            state_nxt = IDLE;
          end else begin
            x_nxt = x + ONE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Row cascade: row1 holds the previous line, row2 the one before it.
  line_buf_1b #(.WIDTH(WIDTH), .AW(AW)) u_row1 (
    .clk   (clk),
    .addr  (lb_addr),
    .we    (lb_we),
    .wdata (in_bit),
    .rdata (row1_rd)
  );

  line_buf_1b #(.WIDTH(WIDTH), .AW(AW)) u_row2 (
    .clk   (clk),
    .addr  (lb_addr),
    .we    (lb_we),
    .wdata (row1_rd),
    .rdata (row2_rd)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      x         <= '0;
      y         <= '0;
      active    <= 1'b0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
      out_value <= '0;
    end else begin
      state  <= state_nxt;
      x      <= x_nxt;
      y      <= y_nxt;
      active <= 1'b1;
      if (emit) begin
        out_valid <= 1'b1;
        out_sof   <= emit_sof;
        out_eol   <= emit_eol;
        out_value <= {RGB_W{emit_bit}};
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Window columns; column 0 of each line starts with a zero left neighbour.
  always_ff @(posedge clk) begin
    if (shift) begin
      col_l <= (x == '0) ? 3'b000 : col_c;
      col_c <= col_r;
    end
  end

endmodule
